// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// funct3 encodings, FSM state type and fault classification.
package lsu_pkg;

  localparam int STRB_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_t;

  function automatic logic lsu_bad(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ill;
    logic mis;
    if (st) ill = f3[2] | (f3[1:0] == 2'b11);
    else    ill = (f3 == 3'b011) | (f3 == 3'b110)
                | (f3 == 3'b111);
    mis = ((f3[1:0] == 2'b01) & off[0])
        | ((f3[1:0] == 2'b10) & (off != 2'b00));
    return ill | mis;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Word-bus request/grant/response handshake
// between the load/store unit and memory.
interface lsu_mem_stage_if
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication/strobes
// and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        i_f3,
  input  logic              i_store,
  input  logic [1:0]        i_off,
  input  logic [XLEN-1:0]   i_sd,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   o_wdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [XLEN-1:0]   o_ldata
);

  logic [XLEN-1:0] w_sh;

  always_comb begin
    w_sh    = i_rdata >> {i_off, 3'b000};
    o_wdata = i_sd;
    o_wstrb = '1;
    o_ldata = w_sh;
    case (i_f3)
      F3_B: begin
        o_ldata = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
        o_wdata = {(XLEN/8){i_sd[7:0]}};
        o_wstrb = STRB_W'(1) << i_off;
      end
      F3_BU: o_ldata = {{(XLEN-8){1'b0}}, w_sh[7:0]};
      F3_H: begin
        o_ldata = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
        o_wdata = {(XLEN/16){i_sd[15:0]}};
        o_wstrb = STRB_W'(3) << i_off;
      end
      F3_HU: o_ldata = {{(XLEN-16){1'b0}}, w_sh[15:0]};
      default: ;
    endcase
    if (!i_store) o_wstrb = '0;
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit: one bus transaction per start,
// with alignment checking and a bus timeout.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  lsu_mem_stage_if.master bus,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            bus_fault
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_sd;
  logic [XLEN-1:0]   r_ld;
  logic [2:0]        r_f3;
  logic              r_st;
  logic              r_mis;
  logic              r_bf;
  logic [TO_W-1:0]   r_cnt;
  logic              w_bad;
  logic              w_to;
  logic              w_cap;
  logic              w_tmo;
  logic              w_req;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_ldata;
  logic [STRB_W-1:0] w_wstrb;

  assign w_bad = lsu_bad(is_store, funct3, addr[1:0]);
  assign w_to  = (r_cnt == TO_W'(TIMEOUT - 1));

  // A response beats the timeout in the same cycle.
  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = w_bad ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (bus.mem_gnt && bus.mem_rvalid) begin
          w_next = S_DONE;
          w_cap  = 1'b1;
        end else if (w_to) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end else if (bus.mem_gnt) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          w_next = S_DONE;
          w_cap  = 1'b1;
        end else if (w_to) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_sd    <= '0;
      r_ld    <= '0;
      r_f3    <= '0;
      r_st    <= 1'b0;
      r_mis   <= 1'b0;
      r_bf    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_addr <= addr;
        r_sd   <= store_data;
        r_f3   <= funct3;
        r_st   <= is_store;
        r_mis  <= w_bad;
        r_bf   <= 1'b0;
        r_cnt  <= '0;
      end
      if (r_state == S_REQ || r_state == S_WAIT)
        r_cnt <= r_cnt + TO_W'(1);
      if (w_tmo) r_bf <= 1'b1;
      if (w_cap && !r_st) r_ld <= w_ldata;
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_f3    (r_f3),
    .i_store (r_st),
    .i_off   (r_addr[1:0]),
    .i_sd    (r_sd),
    .i_rdata (bus.mem_rdata),
    .o_wdata (w_wdata),
    .o_wstrb (w_wstrb),
    .o_ldata (w_ldata)
  );

  assign w_req         = (r_state == S_REQ);
  assign bus.mem_req   = w_req;
  assign bus.mem_we    = w_req & r_st;
  assign bus.mem_addr  = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign bus.mem_wdata = w_req ? w_wdata : '0;
  assign bus.mem_wstrb = w_req ? w_wstrb : '0;

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign load_data  = r_ld;
  assign misaligned = r_mis;
  assign bus_fault  = r_bf;

endmodule
